mem_responder: RTL

//  Data-memory responder for the data_path CPU: the target end of the load/store request

---
 rtl/mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: req/ack data-memory slave for the data_path CPU.
// Inserts WAIT wait states between request accept and ack, and flags
// word addresses at or above DEPTH as errors (access dropped).
// Optional build macro MEMRESP_DEBUG_EN adds dbg_m0..dbg_m3 = array[0..3].
module mem_responder #(
   parameter int AW    = 8,
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   parameter int WAIT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          ack,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy
`ifdef MEMRESP_DEBUG_EN
   ,
   output logic [DW-1:0] dbg_m0,
   output logic [DW-1:0] dbg_m1,
   output logic [DW-1:0] dbg_m2,
   output logic [DW-1:0] dbg_m3
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;

   logic [DW-1:0]   mem [DEPTH];

   // Access being answered: live inputs while idle (so WAIT=0 can go
   // straight to ACK), latched copies once the request is accepted.
   logic            acc_we;
   logic [AW-1:0]   acc_addr;
   logic            acc_oor;

   // State register and latched request, cleared by async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next state, wait counter, request latch and registered response
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = '0;
      err_d    = 1'b0;
      acc_we   = (state_q == S_IDLE) ? we   : we_q;
      acc_addr = (state_q == S_IDLE) ? addr : addr_q;
      acc_oor  = ({1'b0, acc_addr} >= DEPTH_W);

      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               if (WAIT == 0) begin
                  state_d = S_ACK;
                  cnt_d   = '0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_ACK;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Response is registered on the edge entering ACK; zero otherwise
      if (state_d == S_ACK && state_q != S_ACK) begin
         err_d = acc_oor;
         if (!acc_we && !acc_oor) rdata_d = mem[acc_addr];
      end
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      ack   = (state_q == S_ACK);
      busy  = (state_q != S_IDLE);
      rdata = rdata_q;
      err   = err_q;
   end

   // Storage array (not reset): store commits on the edge leaving ACK
   always_ff @(posedge clk) begin
      if (state_q == S_ACK && we_q && !err_q) mem[addr_q] <= wdata_q;
   end

`ifdef MEMRESP_DEBUG_EN
   assign dbg_m0 = mem[0];
   assign dbg_m1 = mem[1];
   assign dbg_m2 = mem[2];
   assign dbg_m3 = mem[3];
`endif

endmodule
